// File: rtl/if_fetch_stage.sv
// Instruction fetch: owns the PC, 0-cycle combinational fetch, 1-cycle redirect; stall holds PC and redirect overrides it.
// Optional build macro FETCH_PERF_CNT_EN adds the perf_fetch_cnt / perf_stall_cnt counters.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] TRAP_PC  = 32'h0000_0100,
  parameter int          IROM_AW  = 14,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pipline_stop,
  input  logic               redirect_valid,
  input  logic [31:0]        redirect_pc,
  output logic [IROM_AW-1:0] irom_addr,
  input  logic [31:0]        irom_data,
  output logic [31:0]        pc_o,
  output logic [31:0]        pc4_o,
  output logic [31:0]        inst_o,
  output logic               misalign_o
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]        perf_fetch_cnt,
  output logic [31:0]        perf_stall_cnt
`endif
);

  logic [31:0] pc_q;
  logic        boot_q;
  logic        misalign_q;

  logic [31:0] pc_seq;
  logic [31:0] redirect_tgt;
  logic        redirect_bad;
  logic [31:0] pc_next;
  logic        misalign_next;
  logic        fetch_adv;
  logic        stall_evt;

  always_comb begin
    pc_seq        = pc_q + 32'd4;
    // jalr semantics: bit 0 of the target is always dropped
    redirect_tgt  = redirect_pc & ~32'd1;
    redirect_bad  = redirect_valid & redirect_pc[1];
    pc_next       = pc_q;
    misalign_next = 1'b0;
    fetch_adv     = 1'b0;
    stall_evt     = 1'b0;
    if (boot_q) begin
      pc_next = pc_q;
    end else if (redirect_bad) begin
      pc_next       = TRAP_PC;
      misalign_next = 1'b1;
      fetch_adv     = 1'b1;
    end else if (redirect_valid) begin
      pc_next   = redirect_tgt;
      fetch_adv = 1'b1;
    end else if (pipline_stop) begin
      pc_next   = pc_q;
      stall_evt = 1'b1;
    end else begin
      pc_next   = pc_seq;
      fetch_adv = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      boot_q     <= 1'b1;
      misalign_q <= 1'b0;
    end else begin
      pc_q       <= pc_next;
      boot_q     <= 1'b0;
      misalign_q <= misalign_next;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_q;
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_cnt_q <= 32'd0;
      stall_cnt_q <= 32'd0;
    end else begin
      if (fetch_adv) fetch_cnt_q <= fetch_cnt_q + 32'd1;
      if (stall_evt) stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign perf_fetch_cnt = fetch_cnt_q;
  assign perf_stall_cnt = stall_cnt_q;
`else
  logic unused_evt;
  assign unused_evt = fetch_adv ^ stall_evt;
`endif

  // Wrong-path squash happens in the same cycle the redirect is seen
  assign pc_o       = pc_q;
  assign pc4_o      = pc_seq;
  assign irom_addr  = pc_q[IROM_AW+1:2];
  assign inst_o     = (boot_q || redirect_valid) ? NOP_INST : irom_data;
  assign misalign_o = misalign_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Randomised + directed bench for if_fetch_stage with a behavioural PC model and per-cycle compare.
module tb_if_fetch_stage;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] TRAP_PC  = 32'h0000_0100;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        stop;
  logic        rv;
  logic [31:0] rpc;
  logic [13:0] irom_addr;
  logic [31:0] irom_data;
  logic [31:0] pc_o, pc4_o, inst_o;
  logic        misalign_o;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt, perf_stall_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  if_fetch_stage dut (
    .clk(clk), .rst(rst), .pipline_stop(stop), .redirect_valid(rv),
    .redirect_pc(rpc), .irom_addr(irom_addr), .irom_data(irom_data),
    .pc_o(pc_o), .pc4_o(pc4_o), .inst_o(inst_o), .misalign_o(misalign_o)
`ifdef FETCH_PERF_CNT_EN
    , .perf_fetch_cnt(perf_fetch_cnt), .perf_stall_cnt(perf_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_word(input logic [13:0] a);
    return 32'hA500_0000 ^ {2'b00, a, ~a, 2'b11};
  endfunction

  assign irom_data = rom_word(irom_addr);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: architectural PC and flags plus event counts
  logic [31:0] m_pc;
  logic        m_boot, m_mis;
  int unsigned m_fetch, m_stall;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pc = RESET_PC; m_boot = 1'b1; m_mis = 1'b0; m_fetch = 0; m_stall = 0;
    end else if (m_boot) begin
      m_boot = 1'b0; m_mis = 1'b0;
    end else if (rv) begin
      m_fetch++;
      m_mis = rpc[1];
      m_pc  = rpc[1] ? TRAP_PC : {rpc[31:1], 1'b0};
    end else if (stop) begin
      m_stall++; m_mis = 1'b0;
    end else begin
      m_fetch++; m_mis = 1'b0; m_pc = m_pc + 32'd4;
    end
  end

  always @(negedge clk) begin
    check("pc", pc_o, m_pc);
    check("pc4", pc4_o, m_pc + 32'd4);
    check("irom_addr", {18'd0, irom_addr}, {18'd0, m_pc[15:2]});
    check("inst", inst_o, (m_boot || rv) ? NOP : rom_word(m_pc[15:2]));
    check("misalign", {31'd0, misalign_o}, {31'd0, m_mis});
`ifdef FETCH_PERF_CNT_EN
    check("fetch_cnt", perf_fetch_cnt, m_fetch);
    check("stall_cnt", perf_stall_cnt, m_stall);
`endif
  end

  task automatic cyc(input logic s, input logic v, input logic [31:0] p);
    stop = s; rv = v; rpc = p;
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; stop = 1'b0; rv = 1'b0; rpc = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    check("lit_rst_pc", pc_o, 32'h0);
    check("lit_rst_inst", inst_o, 32'h0000_0013);
    check("lit_rst_mis", {31'd0, misalign_o}, 32'd0);
    rst = 1'b0;
    #1;
    check("lit_boot_inst", inst_o, 32'h0000_0013);
    cyc(0, 0, 0);
    check("lit_pc0", pc_o, 32'h0);
    check("lit_inst0", inst_o, 32'hA500_FFFF);
    for (int i = 1; i <= 4; i++) begin
      cyc(0, 0, 0);
      check("lit_seq_pc", pc_o, 32'(4 * i));
      check("lit_seq_addr", {18'd0, irom_addr}, 32'(i));
    end
    repeat (3) begin
      cyc(1, 0, 0);
      check("lit_stall_pc", pc_o, 32'h10);
      check("lit_stall_pc4", pc4_o, 32'h14);
    end
    cyc(0, 0, 0);
    check("lit_release", pc_o, 32'h14);
    repeat (3) cyc(0, 0, 0);
    check("lit_at20", pc_o, 32'h20);
    stop = 1'b0; rv = 1'b1; rpc = 32'h81;
    #1;
    check("lit_squash", inst_o, 32'h0000_0013);
    @(posedge clk); #1;
    check("lit_redir_pc", pc_o, 32'h80);
    check("lit_redir_mis", {31'd0, misalign_o}, 32'd0);
    cyc(1, 1, 32'h42);
    check("lit_trap_pc", pc_o, 32'h100);
    check("lit_trap_mis", {31'd0, misalign_o}, 32'd1);
    cyc(0, 0, 0);
    check("lit_mis_clr", {31'd0, misalign_o}, 32'd0);
    check("lit_trap_seq", pc_o, 32'h104);
    cyc(0, 1, 32'hFFFF_FFFC);
    check("lit_wrap_pc4", pc4_o, 32'h0);
    cyc(0, 0, 0);
    check("lit_wrap_pc", pc_o, 32'h0);
    cyc(0, 1, 32'h3C);
    cyc(1, 0, 0);
    check("lit_pc3c", pc_o, 32'h3C);
    rst = 1'b1;
    #1;
    check("lit_async_pc", pc_o, 32'h0);
    check("lit_async_inst", inst_o, 32'h0000_0013);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("lit_reboot_inst", inst_o, 32'h0000_0013);
`ifdef FETCH_PERF_CNT_EN
    check("lit_cnt_f0", perf_fetch_cnt, 32'd0);
    check("lit_cnt_s0", perf_stall_cnt, 32'd0);
`endif
    cyc(0, 0, 0);
    repeat (3) cyc(1, 0, 0);
    repeat (5) cyc(0, 0, 0);
    check("lit_after_pc", pc_o, 32'h14);
`ifdef FETCH_PERF_CNT_EN
    check("lit_cnt_f5", perf_fetch_cnt, 32'd5);
    check("lit_cnt_s3", perf_stall_cnt, 32'd3);
`endif

    repeat (3000) begin
      stop = ($urandom_range(0, 99) < 30);
      rv   = ($urandom_range(0, 9) == 0);
      rpc  = $urandom;
      if ($urandom_range(0, 3) != 0) rpc[1] = 1'b0;
      if ($urandom_range(0, 199) == 0) begin
        rst = 1'b1; #2; rst = 1'b0;
      end
      @(posedge clk); #1;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
